// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer.
// Holds FSM state codes, opcode/funct constants, ALUOp codes, datapath select
// encodings, the instruction-class enum produced by mc_decode, and a helper
// that maps an opcode/funct pair to its ALU operation.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StExe = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  // Opcodes
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  // R-type funct codes
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnJalr = 6'b001001;

  // ALUOp codes
  localparam logic [3:0] AluNop = 4'd0;
  localparam logic [3:0] AluAdd = 4'd1;
  localparam logic [3:0] AluSub = 4'd2;
  localparam logic [3:0] AluAnd = 4'd3;
  localparam logic [3:0] AluOr  = 4'd4;
  localparam logic [3:0] AluSlt = 4'd5;
  localparam logic [3:0] AluSll = 4'd6;
  localparam logic [3:0] AluSrl = 4'd7;
  localparam logic [3:0] AluLui = 4'd8;

  // NPCOp encodings
  localparam logic [1:0] NpcPc4    = 2'b00;
  localparam logic [1:0] NpcBranch = 2'b01;
  localparam logic [1:0] NpcJump   = 2'b10;
  localparam logic [1:0] NpcReg    = 2'b11;

  // WDSel encodings
  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdMem = 2'b01;
  localparam logic [1:0] WdPc  = 2'b10;

  // GPRSel encodings
  localparam logic [1:0] GprRd = 2'b00;
  localparam logic [1:0] GprRt = 2'b01;
  localparam logic [1:0] GprRa = 2'b10;

  typedef enum logic [3:0] {
    ClsRalu,
    ClsShift,
    ClsIalu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump,
    ClsJreg,
    ClsIllegal
  } instr_cls_e;

  function automatic logic [3:0] alu_op_of(input logic [5:0] op, input logic [5:0] funct);
    logic [3:0] res;
    res = AluNop;
    case (op)
      OpRtype: begin
        case (funct)
          FnAdd:   res = AluAdd;
          FnSub:   res = AluSub;
          FnAnd:   res = AluAnd;
          FnOr:    res = AluOr;
          FnSlt:   res = AluSlt;
          FnSll:   res = AluSll;
          FnSrl:   res = AluSrl;
          default: res = AluNop;
        endcase
      end
      OpLw, OpSw, OpAddi: res = AluAdd;
      OpBeq, OpBne:       res = AluSub;
      OpOri:              res = AluOr;
      OpLui:              res = AluLui;
      default:            res = AluNop;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier for mc_ctrl.
// Ports:
//   op_i    - opcode field
//   funct_i - funct field (meaningful for R-type only)
//   cls_o   - instruction class; unsupported encodings map to ClsIllegal
//   link_o  - instruction writes a return address (jal, jalr)
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output instr_cls_e cls_o,
  output logic       link_o
);

  always_comb begin
    cls_o  = ClsIllegal;
    link_o = 1'b0;
    case (op_i)
      OpRtype: begin
        case (funct_i)
          FnAdd, FnSub, FnAnd, FnOr, FnSlt: cls_o = ClsRalu;
          FnSll, FnSrl:                     cls_o = ClsShift;
          FnJr:                             cls_o = ClsJreg;
          FnJalr: begin
            cls_o  = ClsJreg;
            link_o = 1'b1;
          end
          default: cls_o = ClsIllegal;
        endcase
      end
      OpLw:                 cls_o = ClsLoad;
      OpSw:                 cls_o = ClsStore;
      OpBeq, OpBne:         cls_o = ClsBranch;
      OpAddi, OpOri, OpLui: cls_o = ClsIalu;
      OpJ:                  cls_o = ClsJump;
      OpJal: begin
        cls_o  = ClsJump;
        link_o = 1'b1;
      end
      default: cls_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control sequencer for the MIPS datapath.
// Steps each instruction through IF/ID/EXE/MEM/WB and drives datapath selects
// and write enables combinationally from State, Op, Funct and Zero.
// Ports:
//   clk, rst         - clock (rising edge), synchronous active-high reset
//   Op, Funct, Zero  - instruction fields and ALU zero flag
//   MemReady         - memory handshake (only used with MC_CTRL_MEMWAIT_EN)
//   PCWrite..GPRSel  - datapath enables and selects
//   State            - current FSM state (debug)
//   InstrDone        - pulse in the final cycle of each instruction
//   InstrCnt         - retired-instruction counter, wraps
//   Err              - sticky memory timeout flag
// Build option: MC_CTRL_MEMWAIT_EN enables MemReady wait states and timeout.
module mc_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             EXTOp,
  output logic [3:0]       ALUOp,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [1:0]       NPCOp,
  output logic [1:0]       WDSel,
  output logic [1:0]       GPRSel,
  output logic [2:0]       State,
  output logic             InstrDone,
  output logic [CNT_W-1:0] InstrCnt,
  output logic             Err
);
  import mc_ctrl_pkg::*;

  state_e           state_q, state_d;
  instr_cls_e       cls;
  logic             link;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_ok;
  logic [3:0]       alu_op;
  logic             ext_op, src_a, src_b;

  mc_decode u_decode (
    .op_i    (Op),
    .funct_i (Funct),
    .cls_o   (cls),
    .link_o  (link)
  );

  assign alu_op = alu_op_of(Op, Funct);
  assign ext_op = (Op == OpAddi) || (cls inside {ClsLoad, ClsStore, ClsBranch});
  assign src_a  = (cls == ClsShift);
  assign src_b  = cls inside {ClsIalu, ClsLoad, ClsStore};

`ifdef MC_CTRL_MEMWAIT_EN
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  logic [WaitW-1:0] wait_q, wait_d;
  logic             err_q, timeout;
  assign mem_ok = MemReady;
  assign Err    = err_q;
`else
  logic unused_memwait;
  assign unused_memwait = MemReady ^ (MEM_TIMEOUT == 0);
  assign mem_ok = 1'b1;
  assign Err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    EXTOp     = 1'b0;
    ALUOp     = AluNop;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    NPCOp     = NpcPc4;
    WDSel     = WdAlu;
    GPRSel    = GprRd;
    InstrDone = 1'b0;

    // Operand selects persist past EXE so the ALU result is stable for MEM/WB.
    if (state_q inside {StExe, StMem, StWb}) begin
      ALUOp   = alu_op;
      EXTOp   = ext_op;
      ALUSrcA = src_a;
      ALUSrcB = src_b;
    end

    case (state_q)
      StIf: begin
        MemRead = 1'b1;
        if (mem_ok) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StId;
        end
      end
      StId: begin
        case (cls)
          ClsJump, ClsJreg: begin
            PCWrite   = 1'b1;
            NPCOp     = (cls == ClsJump) ? NpcJump : NpcReg;
            InstrDone = 1'b1;
            if (link) begin
              RegWrite = 1'b1;
              WDSel    = WdPc;
              GPRSel   = (cls == ClsJump) ? GprRa : GprRd;
            end
            state_d = StIf;
          end
          ClsIllegal: begin
            InstrDone = 1'b1;
            state_d   = StIf;
          end
          default: state_d = StExe;
        endcase
      end
      StExe: begin
        case (cls)
          ClsBranch: begin
            NPCOp     = NpcBranch;
            // Op[0] distinguishes bne from beq.
            PCWrite   = Op[0] ? ~Zero : Zero;
            InstrDone = 1'b1;
            state_d   = StIf;
          end
          ClsLoad, ClsStore: state_d = StMem;
          default:           state_d = StWb;
        endcase
      end
      StMem: begin
        IorD    = 1'b1;
        MemRead = (cls == ClsLoad);
        if (mem_ok) begin
          if (cls == ClsStore) begin
            MemWrite  = 1'b1;
            InstrDone = 1'b1;
            state_d   = StIf;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        GPRSel    = (cls inside {ClsIalu, ClsLoad}) ? GprRt : GprRd;
        WDSel     = (cls == ClsLoad) ? WdMem : WdAlu;
        state_d   = StIf;
      end
      default: state_d = StIf;
    endcase

`ifdef MC_CTRL_MEMWAIT_EN
    wait_d  = '0;
    timeout = 1'b0;
    if ((state_q == StIf || state_q == StMem) && !MemReady) begin
      if (wait_q == WaitW'(MEM_TIMEOUT - 1)) begin
        timeout = 1'b1;
        state_d = StIf;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
`endif

    if (rst) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      InstrDone = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIf;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (InstrDone) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef MC_CTRL_MEMWAIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      if (timeout) err_q <= 1'b1;
    end
  end
`endif

  assign State    = state_q;
  assign InstrCnt = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl. Each instruction is stepped cycle
// by cycle and the full output vector is compared against hand-derived values.
module tb_mc_ctrl;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      Op, Funct;
  logic            Zero, MemReady;
  logic            PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite;
  logic            EXTOp, ALUSrcA, ALUSrcB;
  logic [3:0]      ALUOp;
  logic [1:0]      NPCOp, WDSel, GPRSel;
  logic [2:0]      State;
  logic            InstrDone, Err;
  logic [CntW-1:0] InstrCnt;

  mc_ctrl #(.CNT_W(CntW), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .NPCOp(NPCOp), .WDSel(WDSel), .GPRSel(GPRSel),
    .State(State), .InstrDone(InstrDone), .InstrCnt(InstrCnt), .Err(Err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [CntW-1:0] exp_cnt;
  logic [5:0]      en;
  logic [22:0]     obs;
  logic [22:0]     v_if;

  // en = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite}
  assign en  = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite};
  assign obs = {State, en, EXTOp, ALUOp, ALUSrcA, ALUSrcB, NPCOp, WDSel, GPRSel, InstrDone};

  function automatic logic [22:0] vec(input logic [2:0] st, input logic [5:0] e,
                                      input logic ext, input logic [3:0] alu,
                                      input logic a, input logic b, input logic [1:0] npc,
                                      input logic [1:0] wd, input logic [1:0] gpr,
                                      input logic dn);
    return {st, e, ext, alu, a, b, npc, wd, gpr, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Op = 6'b000000; Funct = 6'b100000; Zero = 1'b0; MemReady = 1'b1;
    repeat (2) begin
      tick();
      vectors++;
      if (en !== 6'b0 || InstrDone !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_enables: got en=%b done=%b want en=000000 done=0", en, InstrDone);
      end
      vectors++;
      if (State !== 3'd0 || InstrCnt !== 4'd0 || Err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state: got st=%0d cnt=%0d err=%b want 0 0 0", State, InstrCnt, Err);
      end
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== v_if) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", obs, v_if);
    end
    exp_cnt = '0;
  endtask

  task automatic test_alu();
    logic [5:0]  ops [4];
    logic [5:0]  fns [4];
    logic [22:0] want [4][4];
    ops = '{6'b000000, 6'b000000, 6'b001101, 6'b001000};
    fns = '{6'b100000, 6'b000000, 6'b000000, 6'b000000};
    want[0] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 0, 0, 1, 0, 0, 0, 0, 0, 0),
                vec(4, 6'b000001, 0, 1, 0, 0, 0, 0, 0, 1)};
    want[1] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 0, 0, 6, 1, 0, 0, 0, 0, 0),
                vec(4, 6'b000001, 0, 6, 1, 0, 0, 0, 0, 1)};
    want[2] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 0, 0, 4, 0, 1, 0, 0, 0, 0),
                vec(4, 6'b000001, 0, 4, 0, 1, 0, 0, 1, 1)};
    want[3] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 0, 1, 1, 0, 1, 0, 0, 0, 0),
                vec(4, 6'b000001, 1, 1, 0, 1, 0, 0, 1, 1)};
    for (int i = 0; i < 4; i++) begin
      Op = ops[i]; Funct = fns[i]; Zero = 1'b0; #1;
      for (int c = 0; c < 4; c++) begin
        vectors++;
        if (obs !== want[i][c]) begin
          miscompares++;
          $display("FAIL alu[%0d] cycle %0d: got %h want %h", i, c, obs, want[i][c]);
        end
        tick();
      end
      exp_cnt++;
      vectors++;
      if (InstrCnt !== exp_cnt || State !== 3'd0) begin
        miscompares++;
        $display("FAIL alu[%0d] retire: got cnt=%0d st=%0d want cnt=%0d st=0", i, InstrCnt,
                 State, exp_cnt);
      end
    end
  endtask

  task automatic test_mem();
    logic [22:0] want [2][5];
    int          lens [2];
    logic [5:0]  ops  [2];
    ops  = '{6'b100011, 6'b101011};
    lens = '{5, 4};
    want[0] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 0, 1, 1, 0, 1, 0, 0, 0, 0),
                vec(3, 6'b001100, 1, 1, 0, 1, 0, 0, 0, 0),
                vec(4, 6'b000001, 1, 1, 0, 1, 0, 1, 1, 1)};
    want[1] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 0, 1, 1, 0, 1, 0, 0, 0, 0),
                vec(3, 6'b001010, 1, 1, 0, 1, 0, 0, 0, 1), 23'h0};
    for (int i = 0; i < 2; i++) begin
      Op = ops[i]; Funct = 6'b000000; Zero = 1'b0; #1;
      for (int c = 0; c < lens[i]; c++) begin
        vectors++;
        if (obs !== want[i][c]) begin
          miscompares++;
          $display("FAIL mem[%0d] cycle %0d: got %h want %h", i, c, obs, want[i][c]);
        end
        tick();
      end
      exp_cnt++;
      vectors++;
      if (InstrCnt !== exp_cnt || State !== 3'd0) begin
        miscompares++;
        $display("FAIL mem[%0d] retire: got cnt=%0d st=%0d want cnt=%0d st=0", i, InstrCnt,
                 State, exp_cnt);
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [4];
    logic        zs  [4];
    logic [22:0] want [4][3];
    ops = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0};
    want[0] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 6'b100000, 1, 2, 0, 0, 1, 0, 0, 1)};
    want[1] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 6'b000000, 1, 2, 0, 0, 1, 0, 0, 1)};
    want[2] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 6'b000000, 1, 2, 0, 0, 1, 0, 0, 1)};
    want[3] = '{v_if, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), vec(2, 6'b100000, 1, 2, 0, 0, 1, 0, 0, 1)};
    for (int i = 0; i < 4; i++) begin
      Op = ops[i]; Funct = 6'b000000; Zero = zs[i]; #1;
      for (int c = 0; c < 3; c++) begin
        vectors++;
        if (obs !== want[i][c]) begin
          miscompares++;
          $display("FAIL branch[%0d] cycle %0d: got %h want %h", i, c, obs, want[i][c]);
        end
        tick();
      end
      exp_cnt++;
      vectors++;
      if (InstrCnt !== exp_cnt || State !== 3'd0) begin
        miscompares++;
        $display("FAIL branch[%0d] retire: got cnt=%0d st=%0d want cnt=%0d st=0", i, InstrCnt,
                 State, exp_cnt);
      end
    end
  endtask

  // Two-cycle instructions: j, jal, jr, jalr, illegal opcode, illegal funct.
  task automatic test_jump_illegal();
    logic [5:0]  ops [6];
    logic [5:0]  fns [6];
    logic [22:0] want [6];
    ops  = '{6'b000010, 6'b000011, 6'b000000, 6'b000000, 6'b111111, 6'b000000};
    fns  = '{6'b000000, 6'b000000, 6'b001000, 6'b001001, 6'b000000, 6'b111111};
    want = '{vec(1, 6'b100000, 0, 0, 0, 0, 2, 0, 0, 1), vec(1, 6'b100001, 0, 0, 0, 0, 2, 2, 2, 1),
             vec(1, 6'b100000, 0, 0, 0, 0, 3, 0, 0, 1), vec(1, 6'b100001, 0, 0, 0, 0, 3, 2, 0, 1),
             vec(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 1), vec(1, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 1)};
    for (int i = 0; i < 6; i++) begin
      Op = ops[i]; Funct = fns[i]; Zero = 1'b0; #1;
      vectors++;
      if (obs !== v_if) begin
        miscompares++;
        $display("FAIL jump[%0d] IF: got %h want %h", i, obs, v_if);
      end
      tick();
      vectors++;
      if (obs !== want[i]) begin
        miscompares++;
        $display("FAIL jump[%0d] ID: got %h want %h", i, obs, want[i]);
      end
      tick();
      exp_cnt++;
      vectors++;
      if (InstrCnt !== exp_cnt || State !== 3'd0) begin
        miscompares++;
        $display("FAIL jump[%0d] retire: got cnt=%0d st=%0d want cnt=%0d st=0", i, InstrCnt,
                 State, exp_cnt);
      end
    end
  endtask

  // Reset asserted in WB must suppress the write and leave nothing retired.
  task automatic test_reset_mid();
    Op = 6'b000000; Funct = 6'b100000; Zero = 1'b0;
    repeat (3) tick();
    rst = 1'b1; #1;
    vectors++;
    if (State !== 3'd4 || en !== 6'b0 || InstrDone !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mask: got st=%0d en=%b done=%b want st=4 en=000000 done=0", State,
               en, InstrDone);
    end
    tick();
    rst = 1'b0; #1;
    exp_cnt = '0;
    vectors++;
    if (State !== 3'd0 || InstrCnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL reset_mid_state: got st=%0d cnt=%0d want st=0 cnt=0", State, InstrCnt);
    end
  endtask

  // 4-bit counter must wrap from 15 back to 0.
  task automatic test_wrap();
    Op = 6'b000010; Funct = 6'b000000; Zero = 1'b0;
    for (int i = 0; i < 16; i++) begin
      repeat (2) tick();
      exp_cnt++;
      vectors++;
      if (InstrCnt !== exp_cnt) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got cnt=%0d want %0d", i, InstrCnt, exp_cnt);
      end
    end
  endtask

`ifdef MC_CTRL_MEMWAIT_EN
  task automatic test_memwait();
    Op = 6'b000000; Funct = 6'b100000; MemReady = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (State !== 3'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || MemRead !== 1'b1) begin
        miscompares++;
        $display("FAIL if_wait[%0d]: got st=%0d ir=%b pc=%b rd=%b want 0 0 0 1", c, State,
                 IRWrite, PCWrite, MemRead);
      end
      tick();
    end
    MemReady = 1'b1; #1;
    vectors++;
    if (State !== 3'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL if_ready: got st=%0d ir=%b pc=%b want 0 1 1", State, IRWrite, PCWrite);
    end
    repeat (4) tick();
    exp_cnt++;
    vectors++;
    if (State !== 3'd0 || InstrCnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL if_wait_retire: got st=%0d cnt=%0d want 0 %0d", State, InstrCnt, exp_cnt);
    end
    Op = 6'b100011; Funct = 6'b000000;
    repeat (3) tick();
    MemReady = 1'b0; #1;
    for (int c = 0; c < 15; c++) begin
      vectors++;
      if (State !== 3'd3 || Err !== 1'b0) begin
        miscompares++;
        $display("FAIL mem_wait[%0d]: got st=%0d err=%b want 3 0", c, State, Err);
      end
      tick();
    end
    vectors++;
    if (State !== 3'd0 || Err !== 1'b1 || InstrCnt !== exp_cnt) begin
      miscompares++;
      $display("FAIL mem_timeout: got st=%0d err=%b cnt=%0d want 0 1 %0d", State, Err, InstrCnt,
               exp_cnt);
    end
    MemReady = 1'b1;
    tick();
    vectors++;
    if (Err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b want 1", Err);
    end
    repeat (4) tick();
  endtask
`endif

  initial begin
    v_if = vec(0, 6'b110100, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jump_illegal();
    test_reset_mid();
    test_wrap();
`ifdef MC_CTRL_MEMWAIT_EN
    test_memwait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
